// File: rtl/instr_fetch_arbiter_pkg.sv
// Shared constants and types for the unified MIPS32 memory front end:
// default segment bases, the word size and the arbiter state encoding.
package mips_mem_pkg;

   localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
   localparam logic [31:0] DATA_BASE_DEFAULT = 32'h1000_0000;
   localparam logic [31:0] WORD_BYTES        = 32'd4;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   // Force a byte address onto its containing word boundary.
   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instr_fetch_arbiter_if.sv
// Bus bundle between the fetch arbiter, the unified memory and the MEM stage.
// master = arbiter side, slave = memory / MEM-stage side.
interface instr_fetch_arbiter_if;

   logic [31:0] mem_dir;
   logic [31:0] mem_write_data;
   logic        mem_memread;
   logic        mem_memwrite;
   logic [31:0] mem_read_data;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;

   modport master (
      output mem_dir, mem_write_data, mem_memread, mem_memwrite,
      input  mem_read_data,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ack, d_rdata
   );

   modport slave (
      input  mem_dir, mem_write_data, mem_memread, mem_memwrite,
      output mem_read_data,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ack, d_rdata
   );

endinterface

// File: rtl/instr_fetch_arbiter_addr_window_chk.sv
// Address window check: is addr inside [BASE, BASE + 4*WORDS) and word aligned.
// The offset compare is done after subtracting BASE so a window ending at the
// top of the address space cannot wrap.
module addr_window_chk
   import mips_mem_pkg::*;
#(
   parameter logic [31:0] BASE  = 32'h0000_0000,
   parameter int unsigned WORDS = 1
)(
   input  logic [31:0] addr,
   output logic        in_range,
   output logic        aligned
);

   localparam logic [31:0] SPAN = 32'(WORDS) * WORD_BYTES;

   logic [31:0] offset;

   assign offset   = addr - BASE;
   assign in_range = (addr >= BASE) && (offset < SPAN);
   assign aligned  = (addr[1:0] == 2'b00);

endmodule

// File: rtl/instr_fetch_arbiter.sv
// Instruction fetch / data access arbiter for the unified 128x32 memory.
// Owns the PC and the IF instruction register; MEM-stage data requests take
// priority over instruction fetch. Optional performance counters are built
// when the macro PERF_CNT_EN is defined.
module instr_fetch_arbiter
   import mips_mem_pkg::*;
#(
   parameter logic [31:0] TEXT_BASE  = TEXT_BASE_DEFAULT,
   parameter int unsigned TEXT_WORDS = 6,
   parameter logic [31:0] DATA_BASE  = DATA_BASE_DEFAULT,
   parameter int unsigned DATA_WORDS = 32
)(
   input  logic                     clk,
   input  logic                     rst_n,
   instr_fetch_arbiter_if.master    bus,
   input  logic                     stall,
   input  logic                     br_taken,
   input  logic [31:0]              br_target,
   output logic [31:0]              if_instr,
   output logic [31:0]              if_pc,
   output logic                     if_valid,
   output logic                     addr_fault
`ifdef PERF_CNT_EN
   ,
   output logic [31:0]              perf_fetch,
   output logic [31:0]              perf_dstall
`endif
);

   state_t      state;
   logic [31:0] pc;

   logic text_in_range;
   logic text_aligned;
   logic data_in_range;
   logic data_aligned;

   logic data_go;
   logic data_ok;
   logic fetch_want;
   logic fetch_go;
   logic fetch_ok;

   addr_window_chk #(
      .BASE  (TEXT_BASE),
      .WORDS (TEXT_WORDS)
   ) u_text_chk (
      .addr     (pc),
      .in_range (text_in_range),
      .aligned  (text_aligned)
   );

   addr_window_chk #(
      .BASE  (DATA_BASE),
      .WORDS (DATA_WORDS)
   ) u_data_chk (
      .addr     (bus.d_addr),
      .in_range (data_in_range),
      .aligned  (data_aligned)
   );

   // Arbitration: a data request is served unless it was just acked; fetch gets the leftover port.
   always_comb begin
      data_go    = (state != S_BOOT) && bus.d_req && !bus.d_ack;
      data_ok    = data_go && data_in_range && data_aligned;
      fetch_want = (state == S_RUN) && (!stall || !if_valid);
      fetch_go   = fetch_want && !data_go;
      fetch_ok   = fetch_go && text_in_range && text_aligned;
   end

   // Memory port drive; faulting accesses leave the port idle so nothing is read or written.
   always_comb begin
      bus.mem_dir        = '0;
      bus.mem_write_data = '0;
      bus.mem_memread    = 1'b0;
      bus.mem_memwrite   = 1'b0;
      if (data_ok) begin
         bus.mem_dir        = bus.d_addr;
         bus.mem_write_data = bus.d_wdata;
         bus.mem_memread    = !bus.d_we;
         bus.mem_memwrite   = bus.d_we;
      end else if (fetch_ok) begin
         bus.mem_dir     = pc;
         bus.mem_memread = 1'b1;
      end
   end

   // Main FSM: data completion, fetch commit, branch redirect and fault tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_BOOT;
         pc          <= TEXT_BASE;
         if_instr    <= '0;
         if_pc       <= '0;
         if_valid    <= 1'b0;
         addr_fault  <= 1'b0;
         bus.d_ack   <= 1'b0;
         bus.d_rdata <= '0;
      end else begin
         bus.d_ack <= data_go;
         if (data_go) begin
            bus.d_rdata <= (data_ok && !bus.d_we) ? bus.mem_read_data : '0;
            if (!data_ok) begin
               addr_fault <= 1'b1;
            end
         end

         case (state)
            S_BOOT: begin
               state <= S_RUN;
            end
            S_RUN: begin
               if (fetch_go) begin
                  if (!fetch_ok) begin
                     if_valid   <= 1'b0;
                     addr_fault <= 1'b1;
                     state      <= S_HALT;
                  end else if (!br_taken) begin
                     if_instr <= bus.mem_read_data;
                     if_pc    <= pc;
                     if_valid <= 1'b1;
                     pc       <= pc + WORD_BYTES;
                  end
               end
               if (br_taken) begin
                  pc       <= word_align(br_target);
                  if_valid <= 1'b0;
                  if (br_target[1:0] != 2'b00) begin
                     addr_fault <= 1'b1;
                  end
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_BOOT;
            end
         endcase
      end
   end

`ifdef PERF_CNT_EN
   // Count committed fetches and cycles where a wanted fetch lost the port to data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch  <= '0;
         perf_dstall <= '0;
      end else begin
         if (fetch_ok && !br_taken) begin
            perf_fetch <= perf_fetch + 32'd1;
         end
         if (fetch_want && data_go) begin
            perf_dstall <= perf_dstall + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Self-checking bench for instr_fetch_arbiter: a 128x32 memory model (text
// words at index 0.., data words at index 64..), a cycle table for fetch /
// stall / branch behaviour, and hand sequences for data accesses, halting and
// reset. Data completions are checked through an expected-result queue.
module tb_instr_fetch_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        addr_fault;
`ifdef PERF_CNT_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_dstall;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:127];
   logic        text_written;
   logic [31:0] exp_q [$];
   logic [31:0] sb_exp;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] target;
      logic        exp_rd;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      logic        exp_fault;
   } vec_t;

   vec_t vecs [12];

   instr_fetch_arbiter_if bus ();

   instr_fetch_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .if_instr   (if_instr),
      .if_pc      (if_pc),
      .if_valid   (if_valid),
      .addr_fault (addr_fault)
`ifdef PERF_CNT_EN
      ,
      .perf_fetch  (perf_fetch),
      .perf_dstall (perf_dstall)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] mem_idx(input logic [31:0] a);
      return {a[28], a[7:2]};
   endfunction

   // Memory model: combinational read, write on the falling edge.
   assign bus.mem_read_data = mem[mem_idx(bus.mem_dir)];

   always @(negedge clk) begin
      if (bus.mem_memwrite === 1'b1) begin
         mem[mem_idx(bus.mem_dir)] <= bus.mem_write_data;
         if (bus.mem_dir[28] == 1'b0) begin
            text_written <= 1'b1;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      bus.d_req   = req;
      bus.d_we    = we;
      bus.d_addr  = addr;
      bus.d_wdata = wdata;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n     = 1'b0;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = '0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Scoreboard: every d_ack pops the oldest expected load/store result.
   always @(posedge clk) begin
      #1;
      if (bus.d_ack === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb unexpected d_ack: got ack, expected none (d_rdata %h)", bus.d_rdata);
         end else begin
            sb_exp = exp_q.pop_front();
            checkOutput("sb d_rdata", bus.d_rdata, sb_exp);
         end
      end
   end

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      mem[0]  = 32'h2413000A;
      mem[1]  = 32'h2414000A;
      mem[2]  = 32'h0293A820;
      mem[3]  = 32'h3C011000;
      mem[4]  = 32'h34210004;
      mem[5]  = 32'h0000000C;
      mem[64] = 32'hCAFE0000;
      mem[66] = 32'h00000002;
      text_written = 1'b0;

      //                stall br   target        rd    valid if_pc         if_instr      fault
      vecs[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00400000, 32'h2413000A, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00400004, 32'h2414000A, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00400008, 32'h0293A820, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00400008, 32'h0293A820, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00400008, 32'h0293A820, 1'b0};
      vecs[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00400008, 32'h0293A820, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0040000C, 32'h3C011000, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 32'h00400004, 1'b1, 1'b0, 32'h0040000C, 32'h3C011000, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00400004, 32'h2414000A, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 32'h00400006, 1'b1, 1'b0, 32'h00400004, 32'h2414000A, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h00400004, 32'h2414000A, 1'b1};

      // Reset values while rst_n is held low.
      rst_n     = 1'b0;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = '0;
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      #2;
      checkOutput("rst if_valid", if_valid, 0);
      checkOutput("rst if_pc", if_pc, 0);
      checkOutput("rst if_instr", if_instr, 0);
      checkOutput("rst d_ack", bus.d_ack, 0);
      checkOutput("rst d_rdata", bus.d_rdata, 0);
      checkOutput("rst addr_fault", addr_fault, 0);
      checkOutput("rst mem_memread", bus.mem_memread, 0);
      checkOutput("rst mem_memwrite", bus.mem_memwrite, 0);
      checkOutput("rst mem_dir", bus.mem_dir, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Boot, sequential fetch, stall hold, aligned and misaligned redirects.
      for (int i = 0; i < 12; i++) begin
         stall     = vecs[i].stall;
         br_taken  = vecs[i].br;
         br_target = vecs[i].target;
         #1;
         checkOutput($sformatf("row%0d mem_memread", i), bus.mem_memread, vecs[i].exp_rd);
         step();
         checkOutput($sformatf("row%0d if_valid", i), if_valid, vecs[i].exp_valid);
         checkOutput($sformatf("row%0d if_pc", i), if_pc, vecs[i].exp_pc);
         checkOutput($sformatf("row%0d if_instr", i), if_instr, vecs[i].exp_instr);
         checkOutput($sformatf("row%0d addr_fault", i), addr_fault, vecs[i].exp_fault);
      end
      stall    = 1'b0;
      br_taken = 1'b0;

      // Store then load to data space while fetching.
      doReset();
      step();
      step();
      checkOutput("dat first fetch if_pc", if_pc, 32'h00400000);
      applyStimulus(1'b1, 1'b1, 32'h10000004, 32'hDEADBEEF);
      exp_q.push_back(32'h0);
      #1;
      checkOutput("dat store memwrite", bus.mem_memwrite, 1);
      checkOutput("dat store memread", bus.mem_memread, 0);
      checkOutput("dat store mem_dir", bus.mem_dir, 32'h10000004);
      checkOutput("dat store wdata", bus.mem_write_data, 32'hDEADBEEF);
      step();
      checkOutput("dat store d_ack", bus.d_ack, 1);
      checkOutput("dat store if_pc hold", if_pc, 32'h00400000);
      applyStimulus(1'b1, 1'b0, 32'h10000004, 32'h0);
      #1;
      checkOutput("dat ack-cycle fetch memread", bus.mem_memread, 1);
      checkOutput("dat ack-cycle fetch mem_dir", bus.mem_dir, 32'h00400004);
      step();
      checkOutput("dat gap d_ack", bus.d_ack, 0);
      checkOutput("dat gap if_pc", if_pc, 32'h00400004);
      exp_q.push_back(32'hDEADBEEF);
      #1;
      checkOutput("dat load mem_dir", bus.mem_dir, 32'h10000004);
      checkOutput("dat load memread", bus.mem_memread, 1);
      step();
      checkOutput("dat load d_ack", bus.d_ack, 1);
      checkOutput("dat load d_rdata", bus.d_rdata, 32'hDEADBEEF);
      checkOutput("dat load if_pc hold", if_pc, 32'h00400004);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      checkOutput("dat resume if_pc", if_pc, 32'h00400008);
      checkOutput("dat resume d_ack", bus.d_ack, 0);
      checkOutput("dat addr_fault", addr_fault, 0);

      // Store into the text window is refused but still acknowledged.
      doReset();
      step();
      step();
      applyStimulus(1'b1, 1'b1, 32'h00400000, 32'hFFFFFFFF);
      exp_q.push_back(32'h0);
      #1;
      checkOutput("txt store memwrite", bus.mem_memwrite, 0);
      checkOutput("txt store memread", bus.mem_memread, 0);
      step();
      checkOutput("txt store d_ack", bus.d_ack, 1);
      checkOutput("txt store addr_fault", addr_fault, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      step();

      // Asynchronous reset in the middle of a valid store.
      applyStimulus(1'b1, 1'b1, 32'h10000008, 32'h11111111);
      #1;
      checkOutput("arst pre memwrite", bus.mem_memwrite, 1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("arst memwrite", bus.mem_memwrite, 0);
      checkOutput("arst mem_dir", bus.mem_dir, 0);
      checkOutput("arst mem_write_data", bus.mem_write_data, 0);
      checkOutput("arst addr_fault", addr_fault, 0);
      checkOutput("arst if_valid", if_valid, 0);
      checkOutput("arst if_pc", if_pc, 0);
      checkOutput("arst if_instr", if_instr, 0);
      checkOutput("arst d_ack", bus.d_ack, 0);
      #3;
      checkOutput("arst store aborted", mem[66], 32'h00000002);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);

      // Fetch runs off the end of text and halts; data loads still served.
      doReset();
      step();
      repeat (6) step();
      checkOutput("halt last if_pc", if_pc, 32'h00400014);
      checkOutput("halt last if_instr", if_instr, 32'h0000000C);
      #1;
      checkOutput("halt edge memread", bus.mem_memread, 0);
      step();
      checkOutput("halt if_valid", if_valid, 0);
      checkOutput("halt addr_fault", addr_fault, 1);
      #1;
      checkOutput("halt idle memread", bus.mem_memread, 0);
      applyStimulus(1'b1, 1'b0, 32'h10000000, 32'h0);
      exp_q.push_back(32'hCAFE0000);
      #1;
      checkOutput("halt load memread", bus.mem_memread, 1);
      checkOutput("halt load mem_dir", bus.mem_dir, 32'h10000000);
      step();
      checkOutput("halt load d_ack", bus.d_ack, 1);
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      #1;
      checkOutput("halt stays memread", bus.mem_memread, 0);
      checkOutput("halt stays if_valid", if_valid, 0);
      step();

      checkOutput("text never written", text_written, 0);
      checkOutput("pending acks", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
